// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types, constants and helpers for the MM:SS
//                stopwatch/timer: FSM state encoding, the packed BCD time
//                value, the seven-segment lookup table and the BCD
//                increment/decrement/preset-load helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Four BCD digits, most significant first: m10 m1 : s10 s1.
    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
    } mmss_t;

    localparam mmss_t      MMSS_ZERO = '0;
    localparam logic [6:0] MAX_MIN   = 7'd59;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; entry [0] is digit 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1011000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // One-second increment with full ripple; 59:59 wraps to 00:00.
    function automatic mmss_t mmss_inc(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.s1 != 4'd9) begin
            r.s1 = t.s1 + 4'd1;
        end else begin
            r.s1 = 4'd0;
            if (t.s10 != 4'd5) begin
                r.s10 = t.s10 + 4'd1;
            end else begin
                r.s10 = 4'd0;
                if (t.m1 != 4'd9) begin
                    r.m1 = t.m1 + 4'd1;
                end else begin
                    r.m1  = 4'd0;
                    r.m10 = (t.m10 == 4'd5) ? 4'd0 : t.m10 + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // One-second decrement with full borrow ripple.
    function automatic mmss_t mmss_dec(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.s1 != 4'd0) begin
            r.s1 = t.s1 - 4'd1;
        end else begin
            r.s1 = 4'd9;
            if (t.s10 != 4'd0) begin
                r.s10 = t.s10 - 4'd1;
            end else begin
                r.s10 = 4'd5;
                if (t.m1 != 4'd0) begin
                    r.m1 = t.m1 - 4'd1;
                end else begin
                    r.m1  = 4'd9;
                    r.m10 = (t.m10 == 4'd0) ? 4'd5 : t.m10 - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Binary minutes (saturated to 59) to MM:00 in BCD, using a
    // compare/subtract ladder instead of a divider.
    function automatic mmss_t min_to_mmss(input logic [6:0] m);
        mmss_t      r;
        logic [6:0] v;
        logic [3:0] tens;
        v    = (m > MAX_MIN) ? MAX_MIN : m;
        tens = 4'd0;
        if (v >= 7'd50) begin
            tens = 4'd5; v = v - 7'd50;
        end else if (v >= 7'd40) begin
            tens = 4'd4; v = v - 7'd40;
        end else if (v >= 7'd30) begin
            tens = 4'd3; v = v - 7'd30;
        end else if (v >= 7'd20) begin
            tens = 4'd2; v = v - 7'd20;
        end else if (v >= 7'd10) begin
            tens = 4'd1; v = v - 7'd10;
        end
        r     = MMSS_ZERO;
        r.m10 = tens;
        r.m1  = 4'(v);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_dec.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_dec
//  Description : BCD digit to active-low seven-segment pattern. Values above
//                9 show a blank digit.
//  Ports       : bcd_i [3:0] - BCD digit
//                seg_o [6:0] - active-low {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_dec
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_TABLE[bcd_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_mmss.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_mmss
//  Description : Four-digit MM:SS stopwatch / countdown timer driving
//                HEX3..HEX0. Prescaled tick, start/stop, clear and lap
//                freeze on key rising edges; up mode wraps at 59:59, down
//                mode loads a minute preset and stops in DONE at 00:00.
//  Ports       : CLK, RST          - clock, synchronous active-high reset
//                START, CLEAR, LAP - debounced keys, act on rising edge
//                DOWN              - 0 stopwatch, 1 timer (sampled in IDLE)
//                PRESET [10:0]     - [10:4] timer minutes, [3:0] unused
//                HEX3..HEX0 [6:0]  - active-low digit segments
//                RUNNING, DONE     - registered state flags
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_mmss
    import stopwatch_pkg::*;
#(
    parameter int DIV = 50_000_000,
    parameter int PW  = 26
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        CLEAR,
    input  logic        LAP,
    input  logic        DOWN,
    input  logic [10:0] PRESET,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0,
    output logic        RUNNING,
    output logic        DONE
);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    mmss_t         time_q, time_d;
    mmss_t         lap_time_q, lap_time_d;
    logic          down_q, down_d;
    logic          lap_act_q, lap_act_d;
    logic [2:0]    keys_q, keys_prev_q;     // {LAP, CLEAR, START}
    logic          running_q, done_q;

    logic          w_start_edge, w_clear_edge, w_lap_edge, w_tick;
    mmss_t         w_time_step, w_preset_time, w_disp;
    logic          w_unused_preset;

    assign w_start_edge  = keys_q[0] & ~keys_prev_q[0];
    assign w_clear_edge  = keys_q[1] & ~keys_prev_q[1];
    assign w_lap_edge    = keys_q[2] & ~keys_prev_q[2];
    assign w_tick        = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
    assign w_time_step   = down_q ? mmss_dec(time_q) : mmss_inc(time_q);
    assign w_preset_time = min_to_mmss(PRESET[10:4]);

    // Seconds preset is fixed at 00, so the low preset bits carry nothing.
    assign w_unused_preset = ^PRESET[3:0];

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        time_d     = time_q;
        lap_time_d = lap_time_q;
        down_d     = down_q;
        lap_act_d  = lap_act_q;

        if (state_q == ST_RUN) begin
            presc_d = w_tick ? '0 : presc_q + PW'(1);
        end

        if (w_clear_edge) begin
            // Clear wins over everything, including a coincident tick.
            state_d   = ST_IDLE;
            presc_d   = '0;
            time_d    = MMSS_ZERO;
            lap_act_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        presc_d = '0;
                        down_d  = DOWN;
                        if (DOWN) begin
                            time_d  = w_preset_time;
                            state_d = (w_preset_time == MMSS_ZERO) ? ST_DONE : ST_RUN;
                        end else begin
                            time_d  = MMSS_ZERO;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // The tick is applied before a pause request; expiry
                    // takes precedence over pausing.
                    if (w_tick) begin
                        time_d = w_time_step;
                        if (down_q && (w_time_step == MMSS_ZERO)) begin
                            state_d = ST_DONE;
                        end
                    end
                    if (w_start_edge && (state_d != ST_DONE)) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (w_start_edge) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // DONE holds 00:00 until CLEAR.
                end
            endcase

            // Lap yields to a START edge in the same cycle; it latches the
            // pre-tick time.
            if (w_lap_edge && !w_start_edge &&
                ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
                if (lap_act_q) begin
                    lap_act_d = 1'b0;
                end else begin
                    lap_act_d  = 1'b1;
                    lap_time_d = time_q;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            time_q      <= MMSS_ZERO;
            lap_time_q  <= MMSS_ZERO;
            down_q      <= 1'b0;
            lap_act_q   <= 1'b0;
            keys_q      <= 3'b000;
            keys_prev_q <= 3'b000;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            time_q      <= time_d;
            lap_time_q  <= lap_time_d;
            down_q      <= down_d;
            lap_act_q   <= lap_act_d;
            keys_q      <= {LAP, CLEAR, START};
            keys_prev_q <= keys_q;
            running_q   <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign RUNNING = running_q;
    assign DONE    = done_q;

    assign w_disp = lap_act_q ? lap_time_q : time_q;

    logic [3:0][3:0] w_digits;
    logic [3:0][6:0] w_segs;

    assign w_digits = w_disp;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            seg7_dec u_dec (
                .bcd_i (w_digits[gi]),
                .seg_o (w_segs[gi])
            );
        end
    endgenerate

    assign HEX3 = w_segs[3];
    assign HEX2 = w_segs[2];
    assign HEX1 = w_segs[1];
    assign HEX0 = w_segs[0];

endmodule
`default_nettype wire
